// File: rtl/alarm_sequencer_if.sv
// Timer handshake between the alarm sequencer and the shared countdown timer.
// The sequencer is the master: it requests loads and consumes expiry/blink.
interface alarm_sequencer_if;
   logic       start_timer;
   logic [3:0] value;
   logic       expired;
   logic       one_hz_enable;
   logic       half_hz_enable;

   modport master (
      output start_timer,
      output value,
      input  expired,
      input  one_hz_enable,
      input  half_hz_enable
   );

   modport slave (
      input  start_timer,
      input  value,
      output expired,
      output one_hz_enable,
      output half_hz_enable
   );
endinterface

// File: rtl/alarm_sequencer.sv
// Anti-theft alarm controller: sensor decode, timer sequencing,
// siren and status LED drive.
module alarm_sequencer #(
   parameter logic [3:0] T_ARM_DELAY       = 4'd6,
   parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
   parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
   parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ignition,
   input  logic                      door_driver,
   input  logic                      door_pass,
   alarm_sequencer_if.master         tmr,
   output logic                      siren,
   output logic                      status_led,
   output logic [2:0]                state
);

   typedef enum logic [2:0] {
      ARMED           = 3'd0,
      TRIGGERED       = 3'd1,
      SOUND_ALARM     = 3'd2,
      DISARMED        = 3'd3,
      WAIT_DOOR_OPEN  = 3'd4,
      WAIT_DOOR_CLOSE = 3'd5,
      ARM_DELAY       = 3'd6
   } state_e;

   state_e     state_q, state_d;
   logic       start_q, start_d;
   logic [3:0] value_q, value_d;
   logic [1:0] guard_q, guard_d;
   logic       honoured;
   logic       any_door;

   assign any_door = door_driver | door_pass;

   // Expiry counts only after two quiet cycles following the last load,
   // which hides stale pulses and the timer's load latency.
   assign honoured = tmr.expired & ~start_q & (guard_q == 2'd0);

   always_comb begin
      guard_d = 2'd0;
      if (start_q)
         guard_d = 2'd2;
      else if (guard_q != 2'd0)
         guard_d = guard_q - 2'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ARMED;
         start_q <= 1'b0;
         value_q <= 4'd0;
         guard_q <= 2'd0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         value_q <= value_d;
         guard_q <= guard_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      value_d = value_q;
      case (state_q)
         ARMED: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (door_driver) begin
               state_d = TRIGGERED;
               start_d = 1'b1;
               value_d = T_DRIVER_DELAY;
            end else if (door_pass) begin
               state_d = TRIGGERED;
               start_d = 1'b1;
               value_d = T_PASSENGER_DELAY;
            end
         end
         TRIGGERED: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (honoured) begin
               state_d = SOUND_ALARM;
               start_d = 1'b1;
               value_d = T_ALARM_ON;
            end
         end
         SOUND_ALARM: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (any_door) begin
               start_d = 1'b1;
               value_d = T_ALARM_ON;
            end else if (honoured) begin
               state_d = ARMED;
            end
         end
         DISARMED: begin
            if (!ignition)
               state_d = WAIT_DOOR_OPEN;
         end
         WAIT_DOOR_OPEN: begin
            if (ignition)
               state_d = DISARMED;
            else if (door_driver)
               state_d = WAIT_DOOR_CLOSE;
         end
         WAIT_DOOR_CLOSE: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (!any_door) begin
               state_d = ARM_DELAY;
               start_d = 1'b1;
               value_d = T_ARM_DELAY;
            end
         end
         ARM_DELAY: begin
            if (ignition) begin
               state_d = DISARMED;
            end else if (any_door) begin
               start_d = 1'b1;
               value_d = T_ARM_DELAY;
            end else if (honoured) begin
               state_d = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   always_comb begin
      siren      = 1'b0;
      status_led = 1'b0;
      case (state_q)
         ARMED:       status_led = tmr.one_hz_enable;
         TRIGGERED:   status_led = 1'b1;
         SOUND_ALARM: begin
            siren      = 1'b1;
            status_led = 1'b1;
         end
         ARM_DELAY:   status_led = tmr.half_hz_enable;
         default:     status_led = 1'b0;
      endcase
   end

   assign tmr.start_timer = start_q;
   assign tmr.value       = value_q;
   assign state           = state_q;

endmodule
